edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

- Detects rising edges on `N_CH` independent trigger lines and latches each edge as a pending event.
- Offers pending events one at a time to a single shared consumer over a valid/ready handshake, using round-robin arbitration.
- Also flags events lost to coalescing and counts delivered events.
- Sits between the trigger-sourcing logic (already synchronous to `clk`) and whichever downstream block services trigger events.

## Interface
- `N_CH`, default 4: number of trigger channels, ≥2, not necessarily a power of two.
- `CNT_W`, default 8: width of the delivered-event counter.
- `CH_W`, derived as `$clog2(N_CH)`: channel index width; not overridable.
- `clk` in, 1: single clock; all logic is on its rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `trigger` in, N_CH: level inputs, synchronous to `clk`.
- `evt_valid` out, 1: an event is being offered.
- `evt_ch` out, CH_W: channel index of the offered event.
- `evt_ready` in, 1: consumer accepts the offered event.
- `ovf` out, N_CH: sticky per-channel overflow flags.
- `ovf_clr` in, 1: clears all `ovf` bits.
- `evt_count` out, CNT_W: count of accepted events, wraps modulo 2^CNT_W.

## Operation
- **Edge detection:** per channel, `trig_prev[i]` registers `trigger[i]`, reset 0.
  - `rise[i] = trigger[i] & ~trig_prev[i]`.
  - A trigger already high when `rst` deasserts produces one event.
- **Pending flags:** `pending[i]` is set on `rise[i]`. It clears on the cycle its event is accepted (`evt_valid & evt_ready & evt_ch==i`).
- **Same-channel rise and accept:** if `rise[i]` and the accept of channel i occur in the same cycle, `pending[i]` stays 1. The new event is kept and no overflow is recorded.
- **Overflow:** `rise[i]` while `pending[i]=1` and no same-cycle accept of channel i sets `ovf[i]`. The two events merge into one.
  - `ovf` bits are sticky until `ovf_clr`.
  - If a set and `ovf_clr` coincide, the set wins for that bit.
- **FSM states:**
  - IDLE (`evt_valid=0`).
  - OFFER (`evt_valid=1`).
- **FSM transitions:**
  - IDLE → OFFER when any `pending` bit is 1. `evt_ch` is loaded with the winner.
  - OFFER holds while `evt_ready=0`. `evt_ch` must stay stable.
  - On accept in OFFER, the next winner is chosen from the registered `pending` value with the accepted channel masked out. Rises arriving in the accept cycle are not considered.
    - If a candidate exists: stay in OFFER and load the new `evt_ch` (back-to-back delivery, no bubble).
    - Otherwise: go to IDLE.
- **Round-robin:**
  - Pointer `ptr`, reset 0.
  - The winner is the first pending channel found searching `ptr, ptr+1, …, N_CH-1, 0, …` (wrap-around).
  - On accept, `ptr <= (evt_ch+1) mod N_CH`, with explicit wrap for non-power-of-two `N_CH`.
- **Counter:** `evt_count` increments by 1 on every accept and wraps from 2^CNT_W−1 to 0.

## Timing
- **Reset values:** `evt_valid=0`, `evt_ch=0`, `ovf=0`, `evt_count=0`, and all `pending`, `trig_prev` and `ptr` cleared.
- **Reset mid-operation:** asserting `rst` drops `evt_valid` immediately (asynchronous). Any offered and pending events are discarded.
- **Latency:**
  - `trigger[i]` is first sampled high at edge t, which sets `pending[i]`.
  - With the FSM in IDLE, `evt_valid=1` and `evt_ch=i` after edge t+1.
  - Latency is 2 edges from first high sample to offer.
- **Handshake:**
  - Transfer occurs on an edge where `evt_valid & evt_ready`.
  - `evt_ready` may be high while `evt_valid=0`, which has no effect.
  - `evt_valid` never drops without a transfer, except on reset.
- **Throughput:** one event per cycle while events remain pending and `evt_ready=1`.
- **Outputs:** all outputs are registered. There is no combinational path from `trigger` or `evt_ready` to any output.

## Test plan
- **Reset and single event:**
  - Stimulus: release `rst` with `trigger=0`; pulse `trigger[2]` high for 3 cycles; hold `evt_ready=1`.
  - Required: exactly one offer, with `evt_valid` high 2 edges after the first sample, `evt_ch=2`, and `evt_count=1`.
- **Round-robin fairness:**
  - Stimulus: hold `evt_ready=0`; raise `trigger[3:0]=4'b1111` in one cycle; then set `evt_ready=1`.
  - Required: `evt_ch` sequence 0,1,2,3 on consecutive cycles with no bubbles, and `evt_count=4`.
- **Pointer wrap:**
  - Stimulus: after the accept of channel 3, raise channels 0 and 3 together.
  - Required: order 0, then 3.
  - Stimulus: with `N_CH=3`, an accept of channel 2.
  - Required: `ptr=0`.
- **Overflow and clear:**
  - Stimulus: with `evt_ready=0`, create two rises on channel 1.
  - Required: `ovf=4'b0010` and only one event delivered.
  - Stimulus: `ovf_clr` in the same cycle as a new channel-1 overflow.
  - Required: `ovf[1]` stays 1.
  - Stimulus: a plain `ovf_clr`.
  - Required: `ovf` returns to 0.
- **Rise on accept:**
  - Stimulus: rise on channel 0 in the exact cycle channel 0 is accepted.
  - Required: a second channel-0 offer follows and `ovf[0]` stays 0.
- **Backpressure and mid-operation reset:**
  - Stimulus: hold `evt_ready=0` for 10 cycles.
  - Required: `evt_valid` and `evt_ch` stay stable.
  - Stimulus: then assert `rst` asynchronously.
  - Required: `evt_valid` falls before the next edge.
  - Stimulus: after release with `trigger=0`.
  - Required: no events are offered.
- **Counter wrap:**
  - Stimulus: with `CNT_W=2`, deliver 5 events.
  - Required: `evt_count=1`.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - rising-edge event latch with round-robin valid/ready delivery
// Pending events are offered one at a time; lost (coalesced) events raise sticky per-channel ovf flags.
module edge_event_arbiter #(
    parameter int  N_CH  = 4,
    parameter int  CNT_W = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  trigger,
    output logic             evt_valid,
    output logic [CH_W-1:0]  evt_ch,
    input  logic             evt_ready,
    output logic [N_CH-1:0]  ovf,
    input  logic             ovf_clr,
    output logic [CNT_W-1:0] evt_count
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t            state;
    state_t            next_state;
    logic [N_CH-1:0]   trig_prev;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   acc_vec;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_inc;
    logic              accept;
    logic              load_ch;
    logic [N_CH-1:0]   arb_cand;
    logic [CH_W-1:0]   arb_base;
    logic [CH_W-1:0]   arb_win;
    logic              arb_found;

    assign rise    = trigger & ~trig_prev;
    assign accept  = (state == OFFER) && evt_ready;
    assign ptr_inc = (evt_ch == CH_W'(N_CH - 1)) ? '0 : evt_ch + CH_W'(1);

    always_comb begin
        acc_vec = '0;
        if (accept) begin
            acc_vec[evt_ch] = 1'b1;
        end
    end

    // Accept-cycle search uses the registered pending set minus the accepted channel,
    // starting just past it, so same-cycle rises never steal the back-to-back slot.
    always_comb begin
        int idx;
        idx       = 0;
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = (state == OFFER) ? (pending & ~acc_vec) : pending;
        arb_base  = (state == OFFER) ? ptr_inc : ptr;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(arb_base) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!arb_found && arb_cand[idx[CH_W-1:0]]) begin
                arb_found = 1'b1;
                arb_win   = idx[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_ch    = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    next_state = OFFER;
                    load_ch    = 1'b1;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (arb_found) begin
                        load_ch = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        evt_valid = (state == OFFER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev <= '0;
            pending   <= '0;
            ovf       <= '0;
            evt_ch    <= '0;
            ptr       <= '0;
            evt_count <= '0;
        end else begin
            trig_prev <= trigger;
            pending   <= (pending & ~acc_vec) | rise;
            // A rise on an already pending, not-being-accepted channel merges into it.
            ovf       <= (ovf_clr ? '0 : ovf) | (rise & pending & ~acc_vec);
            if (load_ch) begin
                evt_ch <= arb_win;
            end
            if (accept) begin
                ptr       <= ptr_inc;
                evt_count <= evt_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - scoreboard bench for edge_event_arbiter
// Main instance uses defaults; second instance has N_CH=3, CNT_W=2.
module tb_edge_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] trig;
    logic       rdy;
    logic       clr;
    logic       valid;
    logic [1:0] ch;
    logic [3:0] ovf;
    logic [7:0] cnt;

    logic [2:0] trig2;
    logic       rdy2;
    logic       clr2;
    logic       valid2;
    logic [1:0] ch2;
    logic [2:0] ovf2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    logic [1:0] q  [$];
    logic [1:0] q2 [$];

    edge_event_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trig),
        .evt_valid (valid),
        .evt_ch    (ch),
        .evt_ready (rdy),
        .ovf       (ovf),
        .ovf_clr   (clr),
        .evt_count (cnt)
    );

    edge_event_arbiter #(.N_CH(3), .CNT_W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trig2),
        .evt_valid (valid2),
        .evt_ch    (ch2),
        .evt_ready (rdy2),
        .ovf       (ovf2),
        .ovf_clr   (clr2),
        .evt_count (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every transfer pops the next expected channel; a transfer with nothing queued is an error.
    always @(negedge clk) begin
        logic [1:0] e;
        if (!rst && valid && rdy) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL main_offer: got ch=%0d, required no offer", ch);
            end else begin
                e = q.pop_front();
                if (ch !== e) begin
                    errors++;
                    $display("FAIL main_order: got ch=%0d, required ch=%0d", ch, e);
                end
            end
        end
        if (!rst && valid2 && rdy2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL n3_offer: got ch=%0d, required no offer", ch2);
            end else begin
                e = q2.pop_front();
                if (ch2 !== e) begin
                    errors++;
                    $display("FAIL n3_order: got ch=%0d, required ch=%0d", ch2, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        trig  = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        trig2 = '0;
        rdy2  = 1'b0;
        clr2  = 1'b0;
        q.delete();
        q2.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name, input logic [7:0] exp_cnt);
        checks++;
        if (valid !== 1'b0 || cnt !== exp_cnt || q.size() != 0) begin
            errors++;
            $display("FAIL %s: got valid=%0b count=%0d left=%0d, required valid=0 count=%0d left=0",
                     name, valid, cnt, q.size(), exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        trig  = '0;
        rdy   = 1'b0;
        clr   = 1'b0;
        trig2 = '0;
        rdy2  = 1'b0;
        clr2  = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0 || ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_offer: got valid=%0b ch=%0d, required 0 0", valid, ch);
        end
        checks++;
        if (ovf !== 4'b0 || cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_ovf_cnt: got ovf=%b cnt=%0d, required 0000 0", ovf, cnt);
        end
        checks++;
        if (valid2 !== 1'b0 || cnt2 !== 2'd0 || ovf2 !== 3'b0) begin
            errors++;
            $display("FAIL reset_n3: got valid=%0b cnt=%0d ovf=%b, required 0 0 000", valid2, cnt2, ovf2);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        rdy  = 1'b1;
        trig = 4'b0100;
        q.push_back(2'd2);
        tick();
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got valid=%0b one edge after sample, required 0", valid);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || ch !== 2'd2) begin
            errors++;
            $display("FAIL single_latency: got valid=%0b ch=%0d, required 1 2", valid, ch);
        end
        tick();
        trig = '0;
        repeat (3) tick();
        check_drained("single_done", 8'd1);
    endtask

    task automatic test_round_robin();
        do_reset();
        trig = 4'b1111;
        for (int i = 0; i < 4; i++) q.push_back(2'(i));
        tick();
        trig = '0;
        repeat (3) tick();
        checks++;
        if (valid !== 1'b1 || ch !== 2'd0) begin
            errors++;
            $display("FAIL rr_first: got valid=%0b ch=%0d, required 1 0", valid, ch);
        end
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_bubble: got valid=%0b at slot %0d, required 1", valid, i);
            end
            tick();
        end
        check_drained("rr_done", 8'd4);
    endtask

    task automatic test_pointer_wrap();
        trig = 4'b1001;
        q.push_back(2'd0);
        q.push_back(2'd3);
        tick();
        trig = '0;
        repeat (4) tick();
        check_drained("wrap_done", 8'd6);
    endtask

    task automatic test_wrap_n3();
        do_reset();
        rdy2  = 1'b1;
        trig2 = 3'b111;
        for (int i = 0; i < 3; i++) q2.push_back(2'(i));
        tick();
        trig2 = '0;
        repeat (5) tick();
        trig2 = 3'b101;
        q2.push_back(2'd0);
        q2.push_back(2'd2);
        tick();
        trig2 = '0;
        repeat (4) tick();
        checks++;
        if (valid2 !== 1'b0 || cnt2 !== 2'd1 || q2.size() != 0) begin
            errors++;
            $display("FAIL n3_cnt_wrap: got valid=%0b cnt=%0d left=%0d, required 0 1 0", valid2, cnt2, q2.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        trig = 4'b0010;
        q.push_back(2'd1);
        tick();
        trig = '0;
        tick();
        trig = 4'b0010;
        tick();
        trig = '0;
        tick();
        checks++;
        if (ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set: got ovf=%b, required 0010", ovf);
        end
        trig = 4'b0010;
        clr  = 1'b1;
        tick();
        trig = '0;
        clr  = 1'b0;
        checks++;
        if (ovf !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set_wins: got ovf=%b, required 0010", ovf);
        end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b, required 0000", ovf);
        end
        rdy = 1'b1;
        repeat (3) tick();
        rdy = 1'b0;
        check_drained("ovf_one_event", 8'd1);
    endtask

    task automatic test_rise_on_accept();
        do_reset();
        trig = 4'b0001;
        q.push_back(2'd0);
        tick();
        trig = '0;
        tick();
        rdy  = 1'b1;
        trig = 4'b0001;
        q.push_back(2'd0);
        tick();
        trig = '0;
        repeat (4) tick();
        check_drained("roa_second", 8'd2);
        checks++;
        if (ovf !== 4'b0000) begin
            errors++;
            $display("FAIL roa_ovf: got ovf=%b, required 0000", ovf);
        end
    endtask

    task automatic test_backpressure_reset();
        do_reset();
        trig = 4'b0100;
        tick();
        trig = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || ch !== 2'd2) begin
                errors++;
                $display("FAIL bp_stable: got valid=%0b ch=%0d at cycle %0d, required 1 2", valid, ch, i);
            end
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b before next edge, required 0", valid);
        end
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got valid=%0b at cycle %0d, required 0", valid, i);
            end
        end
        check_drained("post_reset_cnt", 8'd0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_wrap_n3();
        test_overflow();
        test_rise_on_accept();
        test_backpressure_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
